// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fsub_cell.sv
// 1-bit combinational full subtractor: d = x - y - bi, bo = borrow out.
module fsub_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, start/done handshake.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    import serial_subtractor_pkg::*;

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t           state, state_d;
    logic [WIDTH-1:0] sa, sa_d;
    logic [WIDTH-1:0] sb, sb_d;
    logic [WIDTH-1:0] res, res_d;
    logic [WIDTH-1:0] diff_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             br, br_d;
    logic             busy_d, done_d, bout_d;
    logic             cell_d, cell_bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf_r, ovf_r_d, ovf_d;
`endif

    fsub_cell u_cell (
        .x  (sa[0]),
        .y  (sb[0]),
        .bi (br),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state;
        sa_d    = sa;
        sb_d    = sb;
        res_d   = res;
        cnt_d   = cnt;
        br_d    = br;
        busy_d  = busy;
        done_d  = 1'b0;
        diff_d  = diff;
        bout_d  = bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_r_d = ovf_r;
        ovf_d   = ovf;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                res_d = {cell_d, res[WIDTH-1:1]};
                sa_d  = {1'b0, sa[WIDTH-1:1]};
                sb_d  = {1'b0, sb[WIDTH-1:1]};
                br_d  = cell_bo;
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    // borrow into MSB vs borrow out of MSB
                    ovf_r_d = br ^ cell_bo;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                diff_d  = res;
                bout_d  = br;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                ovf_d   = ovf_r;
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_r <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            sa    <= sa_d;
            sb    <= sb_d;
            res   <= res_d;
            cnt   <= cnt_d;
            br    <= br_d;
            busy  <= busy_d;
            done  <= done_d;
            diff  <= diff_d;
            bout  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_r <= ovf_r_d;
            ovf   <= ovf_d;
`endif
        end
    end

endmodule
